// File: rtl/fsm_basics_pkg.sv
// Shared definitions for the FSM_BASICS block family: button-conditioner
// state encodings and the default debounce length.
package fsm_basics_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE        = 2'b00,
    BTN_ARM_PRESS   = 2'b01,
    BTN_HELD        = 2'b10,
    BTN_ARM_RELEASE = 2'b11
  } btn_state_e;

  localparam int BTN_DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input. Both flops clear to 0
// on reset; shared by every asynchronous input in the FSM_BASICS family.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // Metastability chain: first flop may go metastable, second resolves it
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronises a raw bouncing pin, debounces it with
// a four-state FSM and emits a debounced level plus one-cycle press/release
// pulses. The press pulse feeds the din input of the downstream detectors.
module btn_debounce_pulse
  import fsm_basics_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEF,
  parameter bit ACTIVE_LOW_BTN  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_pulse,
  output logic       btn_release,
  output logic [1:0] state
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             b;
  logic             s;
  btn_state_e       st;
  logic [CNT_W-1:0] cnt;

  // Polarity is normalised before synchronisation so reset-to-0 means "not pressed"
  assign b = btn_in ^ ACTIVE_LOW_BTN;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (b),
    .q   (s)
  );

  // Debounce FSM, stability counter and registered outputs in one process
  always_ff @(posedge clk) begin
    if (!rst) begin
      st          <= BTN_IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
      case (st)
        BTN_IDLE: begin
          btn_level <= 1'b0;
          if (s) begin
            st  <= BTN_ARM_PRESS;
            cnt <= '0;
          end
        end
        BTN_ARM_PRESS: begin
          if (!s) begin
            // Bounce: drop back without a pulse, counter restarts next time
            st  <= BTN_IDLE;
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            st        <= BTN_HELD;
            cnt       <= '0;
            btn_level <= 1'b1;
            btn_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BTN_HELD: begin
          btn_level <= 1'b1;
          if (!s) begin
            st  <= BTN_ARM_RELEASE;
            cnt <= '0;
          end
        end
        BTN_ARM_RELEASE: begin
          if (s) begin
            // Release bounce: level stays high, no second press pulse
            st  <= BTN_HELD;
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            st          <= BTN_IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          st        <= BTN_IDLE;
          cnt       <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse: clean press, bounce rejection,
// release bounce, reset while held, active-low pin and repeated presses.
module tb_btn_debounce_pulse;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       btn_level;
  logic       btn_pulse;
  logic       btn_release;
  logic [1:0] state;

  logic       al_in;
  logic       al_level;
  logic       al_pulse;
  logic       al_release;
  logic [1:0] al_state;

  int n_cmp;
  int n_bad;
  int n_pulse;
  int n_rel;
  int n_al_pulse;

  btn_debounce_pulse #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW_BTN(1'b0)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .btn_release (btn_release),
    .state       (state)
  );

  btn_debounce_pulse #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW_BTN(1'b1)) u_al (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (al_in),
    .btn_level   (al_level),
    .btn_pulse   (al_pulse),
    .btn_release (al_release),
    .state       (al_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
    if (btn_pulse) n_pulse++;
    if (btn_release) n_rel++;
    if (al_pulse) n_al_pulse++;
    chk("excl", {31'b0, btn_pulse & btn_release}, 32'd0);
  endtask

  // Expected state after each edge once b rises (clean press)
  logic [1:0] press_st [7]  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
  // Bounce pattern 1,1,0,1,1,1,0 then 0 and the expected state trace
  logic       bnc_b    [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [1:0] bnc_st   [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
  // Release pattern 0,0,1,0 then 0 from HELD and expected trace
  logic       rel_b    [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [1:0] rel_st   [10] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};

  // Drive b high and check the full press trace over 7 edges
  task automatic press_trace(input string tag);
    int p0;
    p0 = n_pulse;
    btn_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk({tag, "_st"}, {30'b0, state}, {30'b0, press_st[i]});
      chk({tag, "_pulse"}, {31'b0, btn_pulse}, (i == 6) ? 32'd1 : 32'd0);
      chk({tag, "_lvl"}, {31'b0, btn_level}, (i == 6) ? 32'd1 : 32'd0);
    end
    chk({tag, "_npulse"}, n_pulse - p0, 32'd1);
  endtask

  // Drop b and wait for the release to complete
  task automatic release_clean();
    btn_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("relc_st", {30'b0, state}, 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_pulse = 0; n_rel = 0; n_al_pulse = 0;
    rst = 1'b0; btn_in = 1'b0; al_in = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_st", {30'b0, state}, 32'd0);
    chk("rst_lvl", {31'b0, btn_level}, 32'd0);
    chk("rst_pulse", {31'b0, btn_pulse}, 32'd0);
    chk("rst_rel", {31'b0, btn_release}, 32'd0);
    rst = 1'b1;
    tick(); tick();
    n_pulse = 0; n_rel = 0;

    // Clean press held for 20 cycles: single pulse, level stays high
    press_trace("press");
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("hold_lvl", {31'b0, btn_level}, 32'd1);
      chk("hold_st", {30'b0, state}, 32'd2);
    end
    chk("hold_npulse", n_pulse, 32'd1);

    // Release with bounce from HELD
    for (int i = 0; i < 10; i++) begin
      btn_in = rel_b[i];
      tick();
      chk("rel_st", {30'b0, state}, {30'b0, rel_st[i]});
      chk("rel_rel", {31'b0, btn_release}, (i == 9) ? 32'd1 : 32'd0);
      chk("rel_lvl", {31'b0, btn_level}, (i == 9) ? 32'd0 : 32'd1);
    end
    chk("rel_npulse", n_pulse, 32'd1);
    chk("rel_nrel", n_rel, 32'd1);
    tick(); tick();

    // Bounce rejection from IDLE
    for (int i = 0; i < 12; i++) begin
      btn_in = bnc_b[i];
      tick();
      chk("bnc_st", {30'b0, state}, {30'b0, bnc_st[i]});
      chk("bnc_lvl", {31'b0, btn_level}, 32'd0);
    end
    chk("bnc_npulse", n_pulse, 32'd1);

    // Reset while HELD: no release, then a fresh press after reset
    press_trace("pre_rst");
    tick();
    rst = 1'b0;
    tick();
    chk("mrst_st", {30'b0, state}, 32'd0);
    chk("mrst_lvl", {31'b0, btn_level}, 32'd0);
    chk("mrst_rel", {31'b0, btn_release}, 32'd0);
    chk("mrst_pulse", {31'b0, btn_pulse}, 32'd0);
    chk("mrst_nrel", n_rel, 32'd1);
    rst = 1'b1;
    press_trace("post_rst");
    release_clean();

    // Active-low instance with pin held 1 since reset: no activity
    chk("al_idle_st", {30'b0, al_state}, 32'd0);
    chk("al_idle_lvl", {31'b0, al_level}, 32'd0);
    chk("al_idle_n", n_al_pulse, 32'd0);
    al_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("al_pulse", {31'b0, al_pulse}, (i == 6) ? 32'd1 : 32'd0);
    end
    chk("al_st", {30'b0, al_state}, 32'd2);
    chk("al_n", n_al_pulse, 32'd1);
    al_in = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("al_rel_st", {30'b0, al_state}, 32'd0);

    // Three clean presses: one pulse and one release each
    n_pulse = 0; n_rel = 0;
    for (int k = 0; k < 3; k++) begin
      press_trace("chain");
      release_clean();
    end
    chk("chain_npulse", n_pulse, 32'd3);
    chk("chain_nrel", n_rel, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
# btn_debounce_pulse

Upstream input conditioner for the FSM_BASICS sequence detectors. It turns a raw, asynchronous, bouncing push-button signal into a synchronised, debounced level and a single-cycle press pulse. The pulse output drives the `din` input of the downstream Moore detector, so one physical press produces exactly one `din` cycle.

## Interface
- `DEBOUNCE_CYCLES`, 4: number of consecutive stable synchronised samples needed to accept a press or release; must be ≥ 2.
- `ACTIVE_LOW_BTN`, 0: 1 inverts `btn_in` before synchronisation (pressed = 0 on pin).
- `clk`  input  1  clock.
- `rst`  input  1  reset; synchronous, active-low.
- `btn_in`  input  1  raw button pin; asynchronous to `clk`, may bounce.
- `btn_level`  output  1  debounced pressed level, registered.
- `btn_pulse`  output  1  one-cycle high on each accepted press, registered.
- `btn_release`  output  1  one-cycle high on each accepted release, registered.
- `state`  output  2  current FSM state, for debug and bench observation.

## Operation
- `b` is `btn_in`, XOR-ed with `ACTIVE_LOW_BTN`. It passes through a 2-flop synchroniser; the synchroniser output is `s`.
- Counter `cnt` has width `$clog2(DEBOUNCE_CYCLES)`. It clears on every state change.
- States and encodings:
  - IDLE (2'b00): `btn_level` = 0. If `s` = 1, go to ARM_PRESS.
  - ARM_PRESS (2'b01):
    - If `s` = 0, return to IDLE. This is a bounce and produces no pulse.
    - Otherwise, if `cnt` = `DEBOUNCE_CYCLES`-1, go to HELD, set `btn_level` to 1, and set `btn_pulse` to 1 for one cycle.
    - Otherwise increment `cnt`.
  - HELD (2'b10): `btn_level` = 1. If `s` = 0, go to ARM_RELEASE.
  - ARM_RELEASE (2'b11):
    - If `s` = 1, return to HELD. `btn_level` stays 1 and no second pulse is produced.
    - Otherwise, if `cnt` = `DEBOUNCE_CYCLES`-1, go to IDLE, set `btn_level` to 0, and set `btn_release` to 1 for one cycle.
    - Otherwise increment `cnt`.
- `btn_pulse` and `btn_release` default to 0 every cycle. They are never high together.
- A button held indefinitely gives exactly one `btn_pulse`. `cnt` does not advance in HELD or IDLE.
- Illegal state values cannot occur with 2-bit full encoding. The `default` branch still goes to IDLE with all outputs 0.

## Timing
- Reset, when `rst` = 0 at a rising edge:
  - Synchroniser flops are cleared to 0, which means "not pressed" after polarity.
  - `state` = IDLE, `cnt` = 0.
  - `btn_level` = 0, `btn_pulse` = 0, `btn_release` = 0.
  - Reset takes priority over all logic.
- Reset mid-operation, including in HELD, drops `btn_level` to 0 at that edge and generates no `btn_release`.
- Press latency: `b` is high and stable before edge 0.
  - `s` goes high after edge 1.
  - ARM_PRESS is entered at edge 2.
  - `btn_pulse` and `btn_level` go high after edge 2+`DEBOUNCE_CYCLES`.
  - This gives `DEBOUNCE_CYCLES`+3 edges total: 7 at the default.
- Release latency is symmetric: `btn_level` falls and `btn_release` pulses `DEBOUNCE_CYCLES`+3 edges after `b` goes stable low.
- Any `s` glitch shorter than `DEBOUNCE_CYCLES` cycles in an ARM state is rejected. The counter restarts from 0 on the next entry.
- Minimum spacing between two pulses is 2·(`DEBOUNCE_CYCLES`+1) cycles.

## Structure
- Shared package `fsm_basics_pkg` holds:
  - the state encodings `BTN_IDLE`, `BTN_ARM_PRESS`, `BTN_HELD`, `BTN_ARM_RELEASE`;
  - the default `DEBOUNCE_CYCLES`.
- Sub-module `sync_2ff`: a 2-flop synchroniser with synchronous active-low reset to 0. It is reused for other asynchronous inputs in the design.
- The FSM, counter and output registers live in the top module as one clocked process.

## Test plan
- Clean press: `DEBOUNCE_CYCLES`=4, `b` goes high and stays high for 20 cycles.
  - `btn_pulse` is high for exactly 1 cycle, 7 edges after the rise.
  - `btn_level` is 1 from that edge onward.
  - `state` sequence is 00→01→10.
- Bounce rejection: `b` pattern 1,1,0,1,1,1,0 cycles, then 0.
  - No `btn_pulse` is produced.
  - `btn_level` stays 0.
  - `state` returns to 00 on each 0 sample of `s`.
- Release with bounce: from HELD, `b` pattern 0,0,1,0 then stays 0.
  - The first dip returns `state` to 10 with no pulse.
  - `btn_release` is high for 1 cycle 7 edges after the final fall; `btn_level` goes to 0 at that edge.
- Reset mid-HELD: drive `rst`=0 for one cycle while in 10.
  - Next edge: `state`=00 and all outputs are 0, with no `btn_release`.
  - With `b` still high after reset, a new `btn_pulse` occurs 7 edges after reset deasserts.
- Active-low pin: `ACTIVE_LOW_BTN`=1 and pin driven 0 for 10 cycles gives a single `btn_pulse` at edge 7. The pin held 1 from reset gives no activity.
- Downstream chain: three clean presses into the FSM_1 detector give `dout` sequence 0→1→0. This confirms one `din` per press.
